bitwise_accum: RTL
==================

// Module: bitwise_accum
// PURPOSE
//  Parametrised, registered successor to the single-bit two-input gate. Applies a selectable
//  bitwise op (AND/OR/XOR, optionally inverted) to two WIDTH-bit operands per beat. In
//  accumulate mode it folds the result across a multi-beat burst. Sits between a
//  valid/ready producer and consumer.
// PARAMETERS
//  WIDTH     8   operand/result width in bits (>=1)
//  MAX_BEATS 16  burst-length limit in accumulate mode; beat counter width CNT_W=$clog2(MAX_BEATS+1)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid&in_ready
//  in_a       in   WIDTH  operand a
//  in_b       in   WIDTH  operand b
//  in_last    in   1      last beat of burst (ignored when acc_en=0)
//  op         in   3      [1:0] base: 00 AND, 01 OR, 10 XOR, 11 reserved; [2] invert result
//  acc_en     in   1      1 = accumulate burst, 0 = per-beat
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts when out_valid&out_ready
//  out        out  WIDTH  result
//  out_beats  out  CNT_W  beats folded into out (1 in per-beat mode)
//  err        out  1      result produced with reserved op or burst exceeded MAX_BEATS
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, acc=0, beat count=0, out=0, out_valid=0, out_beats=0,
//   err=0. in_ready=0 while rst_n=0. A burst in flight is discarded with no output.
//  in_ready = ~out_valid | out_ready, in every state.
//  g = base(in_a,in_b): AND a&b, OR a|b, XOR a^b. Reserved base gives g=0 and marks err.
//  Per-beat (acc_en=0 on the accepted beat, state IDLE): out <= g^{WIDTH{op[2]}}.
//   Also out_beats<=1, err<=reserved, out_valid<=1. Latency 1 cycle. Full throughput when
//   out_ready=1.
//  Accumulate: op and acc_en are latched on the first beat (IDLE->ACCUM) and ignored
//   mid-burst.
//   First beat: acc<=g, cnt<=1. Later beats: acc<=acc base g, cnt<=cnt+1.
//   On the in_last beat: out <= (acc base g)^{WIDTH{op[2]}}, out_beats<=cnt+1, out_valid<=1,
//   state->IDLE. Inversion applies only at the final output.
//   A single-beat burst (first beat has in_last) goes IDLE->IDLE and behaves like per-beat.
//   cnt saturates at MAX_BEATS. The beat after saturation still folds into acc, sets a
//   sticky overflow, and err=1 on that burst's result; out_beats then reads MAX_BEATS.
//  Output hold: while out_valid & ~out_ready, out/out_beats/err are held stable and no beat
//   is accepted. out_valid clears on handshake unless a new result loads the same cycle.
//   Back-to-back results are allowed: handshake and new load in one cycle, out_valid stays 1.
//  States: IDLE (no burst open), ACCUM (burst open). Only accepted beats cause transitions;
//   out_valid is independent.
//  in_valid=0 mid-burst: acc and cnt hold indefinitely.
// STRUCTURE
//  Package bitwise_accum_pkg: localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10,
//   OP_RSVD=2'b11; state encoding S_IDLE=1'b0, S_ACCUM=1'b1.
//  One combinational sub-module gate_unit #(WIDTH) (a, b, base[1:0] -> y, rsvd).
//   Instantiated twice: once for g, once for the acc fold.
//  Top level holds the FSM, acc/cnt registers, output register and handshake logic.
// TESTING (WIDTH=8, MAX_BEATS=4)
//  1 Per-beat OR: a=8'hF0, b=8'h0F, op=001, out_ready=1
//    -> next cycle out=8'hFF, out_valid=1, out_beats=1, err=0.
//  2 Per-beat NAND with stall: a=8'hFF, b=8'h0F, op=100, out_ready=0 for 3 cycles
//    -> out=8'hF0 held 3 cycles, in_ready=0, second beat accepted only after the handshake.
//  3 Accumulate XOR, 3 beats (a,b)=(01,00),(02,00),(04,00), last on beat 3, op=010
//    -> one result out=8'h07, out_beats=3; op toggled to 000 mid-burst has no effect.
//  4 Overflow: accumulate OR of 5 beats, a=1<<i, b=0
//    -> out=8'h1F, out_beats=4, err=1.
//  5 Reserved op=011 per-beat -> out=8'h00, err=1.
//    Same with op=111 -> out=8'hFF, err=1.
//  6 Reset mid-burst: 2 beats accepted, rst_n low 1 cycle, then per-beat AND 8'hAA&8'h0F
//    -> out=8'h0A, out_beats=1; no stale partial result is ever emitted.

Source files
------------

// File: rtl/bitwise_accum_pkg.sv
// Shared encodings for the bitwise accumulator: base-op codes and FSM states.
package bitwise_accum_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/gate_unit.sv
// Combinational WIDTH-bit gate: applies the selected base op and flags the reserved code.
module gate_unit
  import bitwise_accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       base,
  output logic [WIDTH-1:0] y,
  output logic             rsvd
);

  always_comb begin
    y    = '0;
    rsvd = 1'b0;
    case (base)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: rsvd = 1'b1;
    endcase
  end

endmodule

// File: rtl/bitwise_accum.sv
// Registered bitwise op unit with optional multi-beat fold, between valid/ready producer and consumer.
module bitwise_accum
  import bitwise_accum_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic [2:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] out_beats,
  output logic             err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [2:0]       cur_op;
  logic [WIDTH-1:0] g, fold, inv_mask;
  logic             g_rsvd, fold_rsvd;
  logic             cnt_sat;

  assign in_ready = rst_n & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Mid-burst beats use the op latched on the first beat.
  assign cur_op   = (state_q == S_ACCUM) ? op_q : op;
  assign inv_mask = {WIDTH{cur_op[2]}};
  assign cnt_sat  = (cnt_q == CNT_W'(MAX_BEATS));

  gate_unit #(.WIDTH(WIDTH)) u_gate_beat (
    .a    (in_a),
    .b    (in_b),
    .base (cur_op[1:0]),
    .y    (g),
    .rsvd (g_rsvd)
  );

  gate_unit #(.WIDTH(WIDTH)) u_gate_fold (
    .a    (acc_q),
    .b    (g),
    .base (cur_op[1:0]),
    .y    (fold),
    .rsvd (fold_rsvd)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ovf_d       = ovf_q;
    out_d       = out_q;
    out_beats_d = out_beats_q;
    err_d       = err_q;
    out_valid_d = out_valid_q & ~out_ready;

    if (accept) begin
      if (state_q == S_IDLE) begin
        if (!acc_en || in_last) begin
          out_d       = g ^ inv_mask;
          out_beats_d = CNT_W'(1);
          err_d       = g_rsvd;
          out_valid_d = 1'b1;
        end else begin
          state_d = S_ACCUM;
          acc_d   = g;
          cnt_d   = CNT_W'(1);
          op_d    = op;
          ovf_d   = 1'b0;
        end
      end else begin
        if (in_last) begin
          out_d       = fold ^ inv_mask;
          out_beats_d = cnt_sat ? CNT_W'(MAX_BEATS) : cnt_q + CNT_W'(1);
          err_d       = fold_rsvd | ovf_q | cnt_sat;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          // Saturated counter keeps folding but remembers the overrun for the result's err.
          acc_d = fold;
          if (cnt_sat) ovf_d = 1'b1;
          else         cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_beats_q <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_beats_q <= out_beats_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_beats = out_beats_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule
